// File: rtl/alu_issue.sv
// alu_issue: RV32I issue/decode stage feeding the integer ALU operand bus.
// It decodes OP, OP-IMM, LUI and AUIPC into an operand bundle and holds the
// results in a registered two-entry skid buffer (output register plus skid
// register).
// Define ALU_ISSUE_PERF_EN to add the perf_issued/perf_illegal transfer counters.
//
// Handshake: a beat moves on a port only in a cycle where valid and ready are
// both high at the rising edge. A producer holds valid and its data stable
// until that edge. in_ready and out_valid come straight from flops, so neither
// depends combinationally on out_ready or in_valid.
module alu_issue #(
   parameter bit ILLEGAL_ZERO = 1'b1
`ifdef ALU_ISSUE_PERF_EN
   ,
   parameter int PERF_W       = 32
`endif
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [31:0]       in_instr,
   input  logic [31:0]       in_pc,
   input  logic [31:0]       in_rs1,
   input  logic [31:0]       in_rs2,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [31:0]       out_in1,
   output logic [31:0]       out_in2,
   output logic              out_is_imm,
   output logic [2:0]        out_funct3,
   output logic [6:0]        out_funct7,
   output logic [4:0]        out_rd,
   output logic              out_illegal
`ifdef ALU_ISSUE_PERF_EN
   ,
   output logic [PERF_W-1:0] perf_issued,
   output logic [PERF_W-1:0] perf_illegal
`endif
);

   typedef struct packed {
      logic [31:0] in1;
      logic [31:0] in2;
      logic        is_imm;
      logic [2:0]  funct3;
      logic [6:0]  funct7;
      logic [4:0]  rd;
      logic        illegal;
   } bundle_t;

   // Buffer occupancy; hierarchically visible as alu_issue.state for debug.
   typedef enum logic [1:0] {
      S_EMPTY = 2'd0,
      S_ONE   = 2'd1,
      S_FULL  = 2'd2
   } state_t;

   localparam logic [6:0] OPC_OP    = 7'b0110011;
   localparam logic [6:0] OPC_IMM   = 7'b0010011;
   localparam logic [6:0] OPC_LUI   = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC = 7'b0010111;

   state_t  state;
   bundle_t out_reg;
   bundle_t skid_reg;
   bundle_t dec;
   logic    in_ready_r;
   logic    out_valid_r;
   logic    accept;
   logic    xfer;

   function automatic bundle_t decode(input logic [31:0] instr,
                                      input logic [31:0] pc,
                                      input logic [31:0] rs1,
                                      input logic [31:0] rs2);
      bundle_t    b;
      logic [2:0] f3;
      logic [6:0] f7;
      f3        = instr[14:12];
      f7        = instr[31:25];
      b.in1     = rs1;
      b.in2     = rs2;
      b.is_imm  = 1'b0;
      b.funct3  = f3;
      b.funct7  = f7;
      b.rd      = instr[11:7];
      b.illegal = 1'b1;
      unique case (instr[6:0])
         OPC_OP: begin
            b.illegal = !((f7 == 7'h00) ||
                          ((f7 == 7'h20) && ((f3 == 3'b000) || (f3 == 3'b101))));
         end
         OPC_IMM: begin
            b.in2    = {{20{instr[31]}}, instr[31:20]};
            b.is_imm = 1'b1;
            if (f3 == 3'b001) begin
               b.illegal = (f7 != 7'h00);
            end else if (f3 == 3'b101) begin
               b.illegal = !((f7 == 7'h00) || (f7 == 7'h20));
            end else begin
               // Immediate bits [31:25] are not a function code here.
               b.funct7  = 7'h00;
               b.illegal = 1'b0;
            end
         end
         OPC_LUI, OPC_AUIPC: begin
            b.in1     = (instr[6:0] == OPC_AUIPC) ? pc : 32'h0;
            b.in2     = {instr[31:12], 12'h000};
            b.is_imm  = 1'b1;
            b.funct3  = 3'b000;
            b.funct7  = 7'h00;
            b.illegal = 1'b0;
         end
         default: begin
            b.illegal = 1'b1;
         end
      endcase
      if (b.illegal && ILLEGAL_ZERO) begin
         b.in1    = 32'h0;
         b.in2    = 32'h0;
         b.funct3 = 3'b000;
         b.funct7 = 7'h00;
      end
      return b;
   endfunction

   assign dec    = decode(in_instr, in_pc, in_rs1, in_rs2);
   assign accept = in_valid && in_ready_r;
   assign xfer   = out_valid_r && out_ready;

   // Occupancy FSM with registered handshake flags and the two data entries.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= S_EMPTY;
         in_ready_r  <= 1'b0;
         out_valid_r <= 1'b0;
         out_reg     <= '0;
         skid_reg    <= '0;
      end else if (flush) begin
         state       <= S_EMPTY;
         in_ready_r  <= 1'b1;
         out_valid_r <= 1'b0;
      end else begin
         unique case (state)
            S_EMPTY: begin
               in_ready_r <= 1'b1;
               if (accept) begin
                  out_reg     <= dec;
                  out_valid_r <= 1'b1;
                  state       <= S_ONE;
               end
            end
            S_ONE: begin
               if (accept && !xfer) begin
                  skid_reg   <= dec;
                  in_ready_r <= 1'b0;
                  state      <= S_FULL;
               end else if (accept && xfer) begin
                  out_reg <= dec;
               end else if (xfer) begin
                  out_valid_r <= 1'b0;
                  state       <= S_EMPTY;
               end
            end
            S_FULL: begin
               if (xfer) begin
                  out_reg    <= skid_reg;
                  in_ready_r <= 1'b1;
                  state      <= S_ONE;
               end
            end
            default: begin
               state       <= S_EMPTY;
               in_ready_r  <= 1'b1;
               out_valid_r <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready    = in_ready_r;
   assign out_valid   = out_valid_r;
   assign out_in1     = out_reg.in1;
   assign out_in2     = out_reg.in2;
   assign out_is_imm  = out_reg.is_imm;
   assign out_funct3  = out_reg.funct3;
   assign out_funct7  = out_reg.funct7;
   assign out_rd      = out_reg.rd;
   assign out_illegal = out_reg.illegal;

`ifdef ALU_ISSUE_PERF_EN
   // Transfer counters; cleared by reset only, so a flush leaves them alone.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         perf_issued  <= '0;
         perf_illegal <= '0;
      end else if (xfer) begin
         perf_issued <= perf_issued + PERF_W'(1);
         if (out_reg.illegal) begin
            perf_illegal <= perf_illegal + PERF_W'(1);
         end
      end
   end
`endif

endmodule

// File: tb/tb_alu_issue.sv
// tb_alu_issue: bench for alu_issue. It runs directed cases from the issue-stage
// behaviour, then random traffic checked against a queue-based reference.
// Build with ALU_ISSUE_PERF_EN defined to also check the transfer counters.
module tb_alu_issue;

   localparam int W = 81;

   logic        clk = 1'b0;
   logic        rst;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_instr;
   logic [31:0] in_pc;
   logic [31:0] in_rs1;
   logic [31:0] in_rs2;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_in1;
   logic [31:0] out_in2;
   logic        out_is_imm;
   logic [2:0]  out_funct3;
   logic [6:0]  out_funct7;
   logic [4:0]  out_rd;
   logic        out_illegal;
`ifdef ALU_ISSUE_PERF_EN
   logic [31:0] perf_issued;
   logic [31:0] perf_illegal;
`endif

   logic [W-1:0] exp_q[$];
   logic [W-1:0] obs;
   logic [31:0]  issued_m = 0;
   logic [31:0]  illegal_m = 0;
   int           vectors = 0;
   int           miscompares = 0;

   alu_issue dut (
      .clk        (clk),
      .rst        (rst),
      .flush      (flush),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_instr   (in_instr),
      .in_pc      (in_pc),
      .in_rs1     (in_rs1),
      .in_rs2     (in_rs2),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_in1    (out_in1),
      .out_in2    (out_in2),
      .out_is_imm (out_is_imm),
      .out_funct3 (out_funct3),
      .out_funct7 (out_funct7),
      .out_rd     (out_rd),
      .out_illegal(out_illegal)
`ifdef ALU_ISSUE_PERF_EN
      ,
      .perf_issued (perf_issued),
      .perf_illegal(perf_illegal)
`endif
   );

   // Clock.
   always #5 clk = ~clk;

   assign obs = {out_in1, out_in2, out_is_imm, out_funct3, out_funct7, out_rd, out_illegal};

   task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [W-1:0] mk(input logic [31:0] a, input logic [31:0] b,
                                       input logic imm, input logic [2:0] f3,
                                       input logic [6:0] f7, input logic [4:0] rd,
                                       input logic ill);
      return {a, b, imm, f3, f7, rd, ill};
   endfunction

   // Reference decode written from the instruction-class rules.
   function automatic logic [W-1:0] ref_decode(input logic [31:0] ins, input logic [31:0] pc,
                                               input logic [31:0] r1, input logic [31:0] r2);
      logic [6:0]  op;
      logic [2:0]  f3;
      logic [6:0]  f7;
      logic [31:0] a;
      logic [31:0] b;
      logic        imm;
      logic        ok;
      op  = ins[6:0];
      f3  = ins[14:12];
      f7  = ins[31:25];
      a   = r1;
      b   = r2;
      imm = 1'b0;
      ok  = 1'b0;
      if (op == 7'h33) begin
         ok = (f7 == 0) || (f7 == 7'h20 && (f3 == 0 || f3 == 5));
      end else if (op == 7'h13) begin
         imm = 1'b1;
         b   = 32'($signed(ins[31:20]));
         if (f3 == 1) ok = (f7 == 0);
         else if (f3 == 5) ok = (f7 == 0 || f7 == 7'h20);
         else begin
            ok = 1'b1;
            f7 = 0;
         end
      end else if (op == 7'h37 || op == 7'h17) begin
         ok  = 1'b1;
         imm = 1'b1;
         a   = (op == 7'h17) ? pc : 32'h0;
         b   = ins & 32'hFFFF_F000;
         f3  = 0;
         f7  = 0;
      end
      if (!ok) begin
         a  = 0;
         b  = 0;
         f3 = 0;
         f7 = 0;
      end
      return mk(a, b, imm, f3, f7, ins[11:7], !ok);
   endfunction

   // Wait for the sampling point and compare the DUT against the model.
   task automatic tick();
      @(negedge clk);
      check("in_ready", in_ready, exp_q.size() < 2);
      check("out_valid", out_valid, exp_q.size() != 0);
      if (exp_q.size() != 0) check("bundle", obs, exp_q[0]);
`ifdef ALU_ISSUE_PERF_EN
      check("perf_issued", perf_issued, issued_m);
      check("perf_illegal", perf_illegal, illegal_m);
`endif
   endtask

   // Drive one cycle of inputs and advance the model for the coming edge.
   task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                        input logic [31:0] r1, input logic [31:0] r2,
                        input logic ordy, input logic fl);
      bit acc;
      bit xf;
      in_valid  = v;
      in_instr  = ins;
      in_pc     = pc;
      in_rs1    = r1;
      in_rs2    = r2;
      out_ready = ordy;
      flush     = fl;
      acc = v && (exp_q.size() < 2);
      xf  = ordy && (exp_q.size() != 0);
      if (xf) begin
         issued_m++;
         if (exp_q[0][0]) illegal_m++;
      end
      if (fl) begin
         exp_q.delete();
      end else begin
         if (xf) void'(exp_q.pop_front());
         if (acc) exp_q.push_back(ref_decode(ins, pc, r1, r2));
      end
   endtask

   function automatic logic [31:0] rand_instr();
      logic [31:0] ins;
      logic [6:0]  f7;
      int          k;
      ins = $urandom;
      k   = $urandom_range(0, 3);
      f7  = (k == 0) ? 7'h00 : (k == 1) ? 7'h20 : (k == 2) ? 7'h01 : 7'($urandom);
      case ($urandom_range(0, 5))
         0: begin ins[6:0] = 7'h33; ins[31:25] = f7; end
         1, 5: begin ins[6:0] = 7'h13; ins[31:25] = f7; end
         2: ins[6:0] = 7'h37;
         3: ins[6:0] = 7'h17;
         default: ;
      endcase
      return ins;
   endfunction

   // Stimulus and final report.
   initial begin
      rst = 1'b0;
      drive(0, 0, 0, 0, 0, 0, 0);
      repeat (2) begin
         @(negedge clk);
         check("rst_out_valid", out_valid, 0);
         check("rst_in_ready", in_ready, 0);
         check("rst_data", obs, 0);
      end
      rst = 1'b1;

      // ADD x3,x1,x2
      tick(); drive(1, 32'h002081B3, 32'h100, 5, 7, 1, 0);
      tick(); check("add", obs, mk(5, 7, 0, 0, 0, 3, 0));
      // SRAI x5,x6,4
      drive(1, 32'h40435293, 32'h104, 32'h80000000, 9, 1, 0);
      tick(); check("srai", obs, mk(32'h80000000, 32'h404, 1, 5, 7'h20, 5, 0));
      // ADDI x1,x0,-1
      drive(1, 32'hFFF00093, 32'h108, 32'h11, 9, 1, 0);
      tick(); check("addi", obs, mk(32'h11, 32'hFFFFFFFF, 1, 0, 0, 1, 0));
      // LUI x2,0x12345
      drive(1, 32'h12345137, 32'h10C, 32'h22, 9, 1, 0);
      tick(); check("lui", obs, mk(0, 32'h12345000, 1, 0, 0, 2, 0));
      // Unknown opcode, then MUL
      drive(1, 32'h0000007F, 32'h110, 32'h33, 32'h44, 1, 0);
      tick(); check("opc7f", obs, mk(0, 0, 0, 0, 0, 0, 1));
      drive(1, 32'h02208133, 32'h114, 32'h33, 32'h44, 1, 0);
      tick(); check("mul", obs, mk(0, 0, 0, 0, 0, 2, 1));
      drive(0, 0, 0, 0, 0, 1, 0);

      // Back-to-back with stalled output
      tick(); drive(1, 32'h002081B3, 32'h200, 5, 7, 0, 0);
      tick(); drive(1, 32'hFFF00093, 32'h204, 32'h11, 0, 0, 0);
      tick(); check("stall_in_ready", in_ready, 0);
      drive(0, 0, 0, 0, 0, 0, 0);
      tick(); drive(0, 0, 0, 0, 0, 0, 0);
      tick(); check("stall_head_add", obs, mk(5, 7, 0, 0, 0, 3, 0));
      drive(0, 0, 0, 0, 0, 1, 0);
      tick(); check("drain_addi", obs, mk(32'h11, 32'hFFFFFFFF, 1, 0, 0, 1, 0));
      check("drain_valid", out_valid, 1);
      drive(0, 0, 0, 0, 0, 1, 0);
      tick(); check("drained", out_valid, 0);

      // Flush while full with an input offered
      drive(1, 32'h002081B3, 32'h300, 1, 2, 0, 0);
      tick(); drive(1, 32'h002081B3, 32'h304, 3, 4, 0, 0);
      tick(); drive(1, 32'h12345137, 32'h308, 0, 0, 0, 1);
      tick(); check("flush_valid", out_valid, 0);
      check("flush_ready", in_ready, 1);
      drive(0, 0, 0, 0, 0, 1, 0);

      // Reset asserted mid-stall
      tick(); drive(1, 32'h00100093, 32'h400, 1, 2, 0, 0);
      tick(); drive(1, 32'h00200093, 32'h404, 1, 2, 0, 0);
      tick(); drive(0, 0, 0, 0, 0, 0, 0);
      @(posedge clk);
      #2 rst = 1'b0;
      #1;
      check("midrst_valid", out_valid, 0);
      check("midrst_ready", in_ready, 0);
      check("midrst_data", obs, 0);
      exp_q.delete();
      issued_m  = 0;
      illegal_m = 0;
      @(negedge clk);
      rst = 1'b1;

      // Random traffic
      for (int i = 0; i < 600; i++) begin
         tick();
         drive($urandom_range(0, 3) != 0, rand_instr(), $urandom, $urandom, $urandom,
               $urandom_range(0, 3) != 0, $urandom_range(0, 31) == 0);
      end
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
